// File: rtl/joystick_uart_tx_if.sv
// -----------------------------------------------------------------------------
// joystick_uart_tx_if
//   Groups the sample/handshake signals of the joystick UART transmitter.
//
//   send  : request to transmit one packet (level-sampled in IDLE)
//   xA    : 10-bit X sample, unsigned, 512 is centre
//   yA    : 10-bit Y sample, unsigned, 512 is centre
//   zBt   : button state
//   Tx    : serial line, idles high
//   busy  : high while a packet is in progress
//   done  : one-cycle pulse when the final stop bit completes
//
//   master : the side that supplies samples and requests packets
//   slave  : the transmitter itself
// -----------------------------------------------------------------------------
interface joystick_uart_tx_if;
    logic       send;
    logic [9:0] xA;
    logic [9:0] yA;
    logic       zBt;
    logic       Tx;
    logic       busy;
    logic       done;

    modport master (
        output send, xA, yA, zBt,
        input  Tx, busy, done
    );

    modport slave (
        input  send, xA, yA, zBt,
        output Tx, busy, done
    );
endinterface

// File: rtl/joystick_uart_tx.sv
// -----------------------------------------------------------------------------
// joystick_uart_tx
//   Serializes a joystick sample into a fixed-format UART packet, 8N1, LSB
//   first. Packet bytes in order:
//     B0 = 0xA5, B1 = X[7:0], B2 = Y[7:0], B3 = {3'b000, zBt, Y[9:8], X[9:8]},
//     B4 = B1^B2^B3 (only when JOYTX_CHECKSUM_EN is defined).
//   Frames are sent back to back with no gap. Inputs are snapshotted when the
//   request is accepted in IDLE; requests while busy are dropped.
//
//   Build option: define JOYTX_CHECKSUM_EN to append the XOR checksum byte.
//
// Ports
//   clk50 : system clock, rising edge
//   reset : synchronous, active-high reset
//   js    : joystick_uart_tx_if.slave (send, xA, yA, zBt in; Tx, busy, done out)
//
// Parameters
//   CLK_HZ       : system clock frequency in Hz
//   BAUD         : line bit rate
//   CLKS_PER_BIT : cycles per bit (>= 2)
// -----------------------------------------------------------------------------
module joystick_uart_tx #(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned BAUD         = 115_200,
    parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic               clk50,
    input  logic               reset,
    joystick_uart_tx_if.slave  js
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
`ifdef JOYTX_CHECKSUM_EN
    localparam int unsigned NUM_BYTES = 5;
`else
    localparam int unsigned NUM_BYTES = 4;
`endif
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BYTE = 3'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;     // baud counter, 0..CLKS_PER_BIT-1
    logic [2:0]       bit_q,   bit_d;     // data bit index within the frame
    logic [2:0]       byte_q,  byte_d;    // byte index within the packet
    logic [7:0]       shift_q, shift_d;   // bit 0 is the data bit on the line
    logic [9:0]       x_q,     x_d;
    logic [9:0]       y_q,     y_d;
    logic             z_q,     z_d;
    logic             tx_q,    tx_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic             baud_tick;
    logic [2:0]       byte_next;
    logic [7:0]       b3;
    logic [7:0]       next_byte;

    assign baud_tick = (cnt_q == CNT_LAST);
    assign byte_next = byte_q + 3'd1;
    assign b3        = {3'b000, z_q, y_q[9:8], x_q[9:8]};

    // Byte following the current one, taken from the snapshot.
    always_comb begin
        next_byte = SYNC_BYTE;
        case (byte_next)
            3'd1:    next_byte = x_q[7:0];
            3'd2:    next_byte = y_q[7:0];
            3'd3:    next_byte = b3;
`ifdef JOYTX_CHECKSUM_EN
            3'd4:    next_byte = x_q[7:0] ^ y_q[7:0] ^ b3;
`endif
            default: next_byte = SYNC_BYTE;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (js.send) begin
                    x_d     = js.xA;
                    y_d     = js.yA;
                    z_d     = js.zBt;
                    byte_d  = 3'd0;
                    bit_d   = 3'd0;
                    shift_d = SYNC_BYTE;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    cnt_d = '0;
                    if (byte_q != LAST_BYTE) begin
                        byte_d  = byte_next;
                        shift_d = next_byte;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are derived from the next state so they appear in the same
        // cycle as the state they describe while still coming from flops.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 3'd0;
            shift_q <= 8'h00;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            z_q     <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign js.Tx   = tx_q;
    assign js.busy = busy_q;
    assign js.done = done_q;

endmodule

// File: tb/tb_joystick_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_joystick_uart_tx
//   Self-checking bench for joystick_uart_tx at CLK_HZ=1000, BAUD=100
//   (10 clocks per bit). A packet-level model predicts Tx/busy/done on every
//   cycle from the byte list and the elapsed time since acceptance; a few
//   literal expectations pin the model's bytes and packet timing.
// -----------------------------------------------------------------------------
module tb_joystick_uart_tx;

    localparam int C = 10;
`ifdef JOYTX_CHECKSUM_EN
    localparam int N = 5;
`else
    localparam int N = 4;
`endif
    localparam int PKT = 10 * N * C;   // cycles from acceptance edge to done edge

    logic clk50 = 1'b0;
    logic reset = 1'b1;
    always #5 clk50 = ~clk50;

    joystick_uart_tx_if js ();

    joystick_uart_tx #(
        .CLK_HZ (1000),
        .BAUD   (100)
    ) dut (
        .clk50 (clk50),
        .reset (reset),
        .js    (js)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural packet model ----------------
    int         cyc         = 0;   // rising edges seen so far
    bit         model_valid = 1'b0;
    bit         in_pkt      = 1'b0;
    int         e           = 0;   // edges since acceptance
    int         acc_edge    = 0;
    logic [7:0] m_bytes [0:4];
    logic       exp_bits [0:49];
    logic       exp_tx   = 1'b1;
    logic       exp_busy = 1'b0;
    logic       exp_done = 1'b0;

    always @(posedge clk50) begin
        cyc = cyc + 1;
        if (reset) begin
            model_valid = 1'b1;
            in_pkt      = 1'b0;
            exp_tx      = 1'b1;
            exp_busy    = 1'b0;
            exp_done    = 1'b0;
        end else if (model_valid) begin
            exp_done = 1'b0;
            if (in_pkt) begin
                e = e + 1;
                if (e == PKT) begin
                    in_pkt   = 1'b0;
                    exp_tx   = 1'b1;
                    exp_busy = 1'b0;
                    exp_done = 1'b1;
                end else begin
                    exp_tx = exp_bits[e / C];
                end
            end else if (js.send) begin
                m_bytes[0] = 8'hA5;
                m_bytes[1] = js.xA[7:0];
                m_bytes[2] = js.yA[7:0];
                m_bytes[3] = {3'b000, js.zBt, js.yA[9:8], js.xA[9:8]};
                m_bytes[4] = m_bytes[1] ^ m_bytes[2] ^ m_bytes[3];
                for (int k = 0; k < N; k++) begin
                    exp_bits[10*k] = 1'b0;
                    for (int i = 0; i < 8; i++) exp_bits[10*k+1+i] = m_bytes[k][i];
                    exp_bits[10*k+9] = 1'b1;
                end
                in_pkt   = 1'b1;
                e        = 0;
                acc_edge = cyc;
                exp_tx   = exp_bits[0];
                exp_busy = 1'b1;
            end else begin
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int   done_cnt  = 0;
    int   done_edge = 0;
    logic busy_prev = 1'b0;
    int   busy_rise [$];

    always @(negedge clk50) begin
        if (model_valid) begin
            check("line", {29'd0, js.Tx, js.busy, js.done}, {29'd0, exp_tx, exp_busy, exp_done});
            if (js.done === 1'b1) begin
                done_cnt++;
                done_edge = cyc;
            end
            if (js.busy === 1'b1 && busy_prev !== 1'b1) busy_rise.push_back(cyc);
            busy_prev = js.busy;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk50);
    endtask

    task automatic check_pkt(input string name, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        logic [7:0] want [0:4];
        want[0] = b0; want[1] = b1; want[2] = b2; want[3] = b3; want[4] = b4;
        for (int k = 0; k < N; k++) check(name, {24'd0, m_bytes[k]}, {24'd0, want[k]});
    endtask

    int d0;
    int r0;

    initial begin
        js.send = 1'b0;
        js.xA   = 10'd0;
        js.yA   = 10'd0;
        js.zBt  = 1'b0;

        // Reset idle: 3 reset cycles, then 50 quiet cycles.
        @(negedge clk50);
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(50);
        check("idle_no_done", done_cnt, 0);
        check("idle_no_busy", busy_rise.size(), 0);

        // Single packet: B3 = {000,1,10,01} = 0x19, B4 = 55^AA^19 = E6.
        js.xA = 10'h155; js.yA = 10'h2AA; js.zBt = 1'b1; js.send = 1'b1;
        wait_cyc(1);
        js.send = 1'b0;
        check_pkt("single_bytes", 8'hA5, 8'h55, 8'hAA, 8'h19, 8'hE6);
        r0 = acc_edge;
        // Snapshot/ignore: new sample and a second request 100 cycles in.
        wait_cyc(99);
        js.xA = 10'h000; js.send = 1'b1;
        wait_cyc(1);
        js.send = 1'b0;
        wait_cyc(PKT);
        check("single_done_cnt", done_cnt, 1);
        // done is visible in cycle T+10*N*C+1, i.e. launched by edge T+10*N*C
        // (T+500 with checksum, T+400 without).
`ifdef JOYTX_CHECKSUM_EN
        check("single_done_time", done_edge - r0, 500);
`else
        check("single_done_time", done_edge - r0, 400);
`endif
        check("snapshot_b1", {24'd0, m_bytes[1]}, 32'h55);
        check("busy_from_T", busy_rise[busy_rise.size()-1], r0);

        // Back-to-back: send held high, two packets accepted.
        wait_cyc(5);
        d0 = busy_rise.size();
        js.xA = 10'h3FF; js.yA = 10'h000; js.zBt = 1'b0; js.send = 1'b1;
        wait_cyc(1);
        check_pkt("b2b_bytes", 8'hA5, 8'hFF, 8'h00, 8'h03, 8'hFC);
        wait_cyc(599);
        js.send = 1'b0;
        wait_cyc(PKT);
        check("b2b_pkts", busy_rise.size() - d0, 2);
        if (busy_rise.size() - d0 == 2)
            // Next acceptance one cycle after done: start bit at T+10*N*C+2.
            check("b2b_spacing", busy_rise[d0+1] - busy_rise[d0], PKT + 1);
        check_pkt("b2b_bytes2", 8'hA5, 8'hFF, 8'h00, 8'h03, 8'hFC);

        // Reset mid-packet at edge T+137.
        d0 = done_cnt;
        js.xA = 10'h155; js.yA = 10'h2AA; js.zBt = 1'b1; js.send = 1'b1;
        wait_cyc(1);
        js.send = 1'b0;
        wait_cyc(136);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        check("abort_lines", {29'd0, js.Tx, js.busy, js.done}, 32'h4);
        wait_cyc(PKT);
        check("abort_no_done", done_cnt, d0);
        js.xA = 10'h0F0; js.yA = 10'h30F; js.zBt = 1'b0; js.send = 1'b1;
        wait_cyc(1);
        js.send = 1'b0;
        check_pkt("after_abort_bytes", 8'hA5, 8'hF0, 8'h0F, 8'h0C, 8'hF3);
        wait_cyc(PKT + 5);
        check("after_abort_done", done_cnt, d0 + 1);

        // Randomized traffic: random samples, stray requests, input churn,
        // occasional resets in flight.
        for (int it = 0; it < 16; it++) begin
            js.xA = 10'($urandom); js.yA = 10'($urandom); js.zBt = 1'($urandom);
            js.send = 1'b1;
            wait_cyc($urandom_range(1, 3));
            js.send = 1'b0;
            for (int c = 0; c < $urandom_range(PKT - 100, PKT + 60); c++) begin
                if ($urandom_range(0, 9) == 0) js.xA = 10'($urandom);
                if ($urandom_range(0, 9) == 0) js.yA = 10'($urandom);
                if ($urandom_range(0, 9) == 0) js.zBt = 1'($urandom);
                js.send = ($urandom_range(0, 49) == 0);
                reset   = (it % 5 == 3) && (c == 211);
                wait_cyc(1);
            end
            js.send = 1'b0;
            reset   = 1'b0;
        end

        wait_cyc(PKT + 20);
        check("final_idle", {30'd0, js.Tx, js.busy}, 32'h2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
